// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
//
// Converts a WIDTH-bit binary value (two's complement when SIGNED=1, unsigned
// when SIGNED=0) into a DIGITS-digit BCD magnitude plus a sign flag. It uses a
// sequential shift-add-3 (double dabble) datapath with one input bit per clock,
// so each conversion takes WIDTH cycles.
//
// Optional feature macro: BCD_CONVERTER_LZB_EN
//   When it is defined, digit_mask is a registered leading-zero-blanking mask.
//   When it is undefined, digit_mask is tied to all ones and no blanking logic
//   exists.
//
// Parameters
//   WIDTH  : binary input width (2..64)
//   DIGITS : number of BCD output digits (1..20)
//   SIGNED : 1 = bin is two's complement, 0 = bin is unsigned
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request to convert bin
//   in_ready   : converter can accept (IDLE only)
//   bin        : value to convert, sampled on accept
//   out_valid  : result registers hold a completed conversion
//   out_ready  : consumer takes the result
//   bcd        : result magnitude, digit k at [4k+3:4k]
//   sign       : input was negative
//   overflow   : magnitude did not fit in DIGITS digits
//   digit_mask : 1 = significant digit
// -----------------------------------------------------------------------------
module bcd_converter #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow,
    output logic [DIGITS-1:0]     digit_mask
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DABBLE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [WIDTH-1:0] mag;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bcd_q;
    logic             sign_q;
    logic             ovf_q;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    shifted;

    // Add 3 to every digit that is 5 or more, so that the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Absolute value as an unsigned WIDTH-bit quantity. Negating the most
    // negative value wraps to the same bit pattern, which read as unsigned is
    // exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sb;
        sb = b;
        if ((SIGNED != 0) && b[WIDTH-1])
            return $unsigned(-sb);
        else
            return b;
    endfunction

    assign adj     = add3_digits(bcd_q);
    assign shifted = {adj[BW-2:0], mag[cnt]};

    // Control: next-state and handshake decode
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid)    state_nxt = DABBLE;
            DABBLE:  if (cnt == '0)   state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bcd_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
            mag    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag    <= magnitude(bin);
                        sign_q <= (SIGNED != 0) && bin[WIDTH-1];
                        bcd_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt    <= CW'(WIDTH - 1);
                    end
                end
                DABBLE: begin
                    // The bit leaving the top digit is lost; remember that.
                    bcd_q <= shifted;
                    ovf_q <= ovf_q | adj[BW-1];
                    cnt   <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd      = bcd_q;
    assign sign     = sign_q;
    assign overflow = ovf_q;

`ifdef BCD_CONVERTER_LZB_EN
    logic [DIGITS-1:0] mask_q;

    // Bit k is set when any digit at or above k is nonzero; digit 0 always
    // shows so that a zero result still displays a single "0".
    function automatic logic [DIGITS-1:0] lzb_mask(input logic [BW-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen;
        seen = 1'b0;
        m    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (|v[4*k +: 4]);
            m[k] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    // Captured from the final shifted value on the DONE-entry edge.
    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= DIGITS'(1);
        else if ((state == DABBLE) && (cnt == '0))
            mask_q <= lzb_mask(shifted);
    end

    assign digit_mask = mask_q;
`else
    assign digit_mask = '1;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
//
// Directed self-checking bench for bcd_converter. Three instances share one
// clock: a (WIDTH=32, DIGITS=10, SIGNED=1), b (WIDTH=10, DIGITS=3, SIGNED=0)
// and c (WIDTH=32, DIGITS=10, SIGNED=0). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_bcd_converter;

`ifdef BCD_CONVERTER_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  sign_v;
    logic [2:0]  ovf_v;

    logic [31:0] bin_a;
    logic [9:0]  bin_b;
    logic [31:0] bin_c;
    logic [39:0] bcd_a;
    logic [11:0] bcd_b;
    logic [39:0] bcd_c;
    logic [9:0]  dm_a;
    logic [2:0]  dm_b;
    logic [9:0]  dm_c;

    int n_total;
    int n_fail;

    bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .bin(bin_a),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .bcd(bcd_a), .sign(sign_v[0]), .overflow(ovf_v[0]), .digit_mask(dm_a)
    );

    bcd_converter #(.WIDTH(10), .DIGITS(3), .SIGNED(0)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .bin(bin_b),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .bcd(bcd_b), .sign(sign_v[1]), .overflow(ovf_v[1]), .digit_mask(dm_b)
    );

    bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .bin(bin_c),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .bcd(bcd_c), .sign(sign_v[2]), .overflow(ovf_v[2]), .digit_mask(dm_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] get_bcd(input int sel);
        case (sel)
            0:       return bcd_a;
            1:       return {28'd0, bcd_b};
            default: return bcd_c;
        endcase
    endfunction

    function automatic logic [9:0] get_mask(input int sel);
        case (sel)
            0:       return dm_a;
            1:       return {7'd0, dm_b};
            default: return dm_c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int sel, input logic [31:0] b);
        case (sel)
            0:       bin_a = b;
            1:       bin_b = b[9:0];
            default: bin_c = b;
        endcase
        in_valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!out_valid_v[sel] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_result(input int sel, input string tag, input logic [39:0] e_bcd,
                                input logic e_sign, input logic e_ovf, input logic [9:0] e_mask);
        check({tag, " bcd"},  64'(get_bcd(sel)), 64'(e_bcd));
        check({tag, " sign"}, 64'(sign_v[sel]),  64'(e_sign));
        check({tag, " ovf"},  64'(ovf_v[sel]),   64'(e_ovf));
        check({tag, " mask"}, 64'(get_mask(sel)), 64'(e_mask));
    endtask

    task automatic release_out(input int sel, input string tag);
        out_ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[sel] = 1'b0;
        check({tag, " idle in_ready"},  64'(in_ready_v[sel]),  64'(1));
        check({tag, " idle out_valid"}, 64'(out_valid_v[sel]), 64'(0));
    endtask

    initial begin
        n_total     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        bin_a       = '0;
        bin_b       = '0;
        bin_c       = '0;

        // Reset state, with a request pending to show rst has priority
        in_valid_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst a out_valid", 64'(out_valid_v[0]), 64'(0));
        check("rst a in_ready",  64'(in_ready_v[0]),  64'(1));
        check_result(0, "rst a", 40'h0, 1'b0, 1'b0, LZB ? 10'h001 : 10'h3FF);
        check_result(1, "rst b", 40'h0, 1'b0, 1'b0, LZB ? 10'h001 : 10'h007);
        in_valid_v[0] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-rst in_ready", 64'(in_ready_v), 64'(3'b111));
        check("post-rst out_valid", 64'(out_valid_v), 64'(3'b000));

        // Signed 32-bit vectors
        start(0, 32'd0);
        wait_done(0, 32, "zero");
        check_result(0, "zero", 40'h0, 1'b0, 1'b0, LZB ? 10'h001 : 10'h3FF);
        release_out(0, "zero");

        start(0, 32'hFFFF_FFFF);
        wait_done(0, 32, "neg1");
        check_result(0, "neg1", 40'h0000000001, 1'b1, 1'b0, LZB ? 10'h001 : 10'h3FF);
        release_out(0, "neg1");

        start(0, 32'd2147483647);
        wait_done(0, 32, "maxpos");
        check_result(0, "maxpos", 40'h2147483647, 1'b0, 1'b0, 10'h3FF);
        release_out(0, "maxpos");

        start(0, 32'h8000_0000);
        wait_done(0, 32, "maxneg");
        check_result(0, "maxneg", 40'h2147483648, 1'b1, 1'b0, 10'h3FF);
        release_out(0, "maxneg");

        start(0, 32'hFFFF_FF85);   // -123
        wait_done(0, 32, "neg123");
        check_result(0, "neg123", 40'h0000000123, 1'b1, 1'b0, LZB ? 10'h007 : 10'h3FF);
        release_out(0, "neg123");

        // Narrow unsigned instance, including overflow
        start(1, 32'd999);
        wait_done(1, 10, "u10 999");
        check_result(1, "u10 999", 40'h999, 1'b0, 1'b0, 10'h007);
        release_out(1, "u10 999");

        start(1, 32'd1023);
        wait_done(1, 10, "u10 1023");
        check_result(1, "u10 1023", 40'h023, 1'b0, 1'b1, LZB ? 10'h003 : 10'h007);
        release_out(1, "u10 1023");

        start(1, 32'd7);
        wait_done(1, 10, "u10 7");
        check_result(1, "u10 7", 40'h007, 1'b0, 1'b0, LZB ? 10'h001 : 10'h007);
        release_out(1, "u10 7");

        // Unsigned 32-bit instance: top bit is data, not sign
        start(2, 32'hFFFF_FFFF);
        wait_done(2, 32, "u32 max");
        check_result(2, "u32 max", 40'h4294967295, 1'b0, 1'b0, 10'h3FF);
        release_out(2, "u32 max");

        start(2, 32'h8000_0000);
        wait_done(2, 32, "u32 msb");
        check_result(2, "u32 msb", 40'h2147483648, 1'b0, 1'b0, 10'h3FF);
        release_out(2, "u32 msb");

        // Backpressure: result held, second request ignored
        start(0, 32'd12345);
        wait_done(0, 32, "bp");
        bin_a = 32'd777;
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold out_valid", 64'(out_valid_v[0]), 64'(1));
            check("bp hold in_ready",  64'(in_ready_v[0]),  64'(0));
            check("bp hold bcd",       64'(bcd_a),          64'(40'h0000012345));
        end
        in_valid_v[0] = 1'b0;
        check_result(0, "bp", 40'h0000012345, 1'b0, 1'b0, LZB ? 10'h01F : 10'h3FF);
        release_out(0, "bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp no restart out_valid", 64'(out_valid_v[0]), 64'(0));
        check("bp no restart in_ready",  64'(in_ready_v[0]),  64'(1));
        check("bp result kept",          64'(bcd_a),          64'(40'h0000012345));

        // Reset in the middle of a conversion (10th DABBLE edge)
        start(0, 32'hFFFF_FC18);   // -1000
        repeat (9) @(posedge clk);
        #1;
        check("mid in_ready low", 64'(in_ready_v[0]), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst in_ready",  64'(in_ready_v[0]),  64'(1));
        check("mid rst out_valid", 64'(out_valid_v[0]), 64'(0));
        check_result(0, "mid rst", 40'h0, 1'b0, 1'b0, LZB ? 10'h001 : 10'h3FF);
        start(0, 32'd9876543);
        wait_done(0, 32, "after rst");
        check_result(0, "after rst", 40'h0009876543, 1'b0, 1'b0, LZB ? 10'h07F : 10'h3FF);
        release_out(0, "after rst");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
